// File: rtl/ps2_kbd_controller.sv
// ============================================================================
// Module   : ps2_kbd_controller
// Purpose  : Z180 I/O-mapped PS/2 keyboard receiver with scan-code FIFO,
//            DATA/STATUS registers and a maskable active-low interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_kbd_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SAMPLE_DELAY   = 8,
    parameter int TIMEOUT_CYCLES = 36864
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_N,
    input  logic       IOREQ,
    input  logic       R,
    input  logic       W,
    input  logic       ADDR0,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    output logic       INT_N
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SMP_W = $clog2(SAMPLE_DELAY + 2);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic             kb_clk_s1_q, kb_clk_s1_d, kb_clk_s2_q, kb_clk_s2_d;
    logic             kb_data_s1_q, kb_data_s1_d, kb_data_s2_q, kb_data_s2_d;
    logic [SMP_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d, ie_q, ie_d;
    logic             int_n_q, int_n_d;
    logic             rd_acc_q, rd_acc_d, wr_acc_q, wr_acc_d, addr0_q, addr0_d;

    logic             sample, bit_val, push_req, ferr_set, perr_set;
    logic             rd_acc, wr_acc, wr_edge, stat_wr, flush;
    logic             full, nempty, pop_req, do_push, ovf_set;
    logic [7:0]       status, head;
    logic             unused_data_in_bits;

    assign unused_data_in_bits = &{1'b0, DATA_IN[6:5], DATA_IN[1]};

    // Synchroniser and low-period sample counter (saturates so only one bit per low)
    always_comb begin
        kb_clk_s1_d  = KB_CLK;
        kb_clk_s2_d  = kb_clk_s1_q;
        kb_data_s1_d = KB_DATA;
        kb_data_s2_d = kb_data_s1_q;
        sample_cnt_d = sample_cnt_q;
        if (kb_clk_s2_q)
            sample_cnt_d = '0;
        else if (sample_cnt_q != SMP_W'(SAMPLE_DELAY + 1))
            sample_cnt_d = sample_cnt_q + SMP_W'(1);
    end

    assign sample  = ~kb_clk_s2_q & (sample_cnt_q == SMP_W'(SAMPLE_DELAY));
    assign bit_val = kb_data_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timeout_d = '0;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample && !bit_val) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    parity_d = bit_val;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    state_d = ST_IDLE;
                    if (!bit_val)
                        ferr_set = 1'b1;
                    else if (^{shift_q, parity_q})
                        push_req = 1'b1;
                    else
                        perr_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !sample) begin
            if (timeout_q == TO_W'(TIMEOUT_CYCLES)) begin
                state_d  = ST_IDLE;
                ferr_set = 1'b1;
            end else begin
                timeout_d = timeout_q + TO_W'(1);
            end
        end
    end

    // Bus decode; pop is deferred to the cycle after a DATA read ends
    assign rd_acc  = ~CS_N & ~IOREQ & ~R;
    assign wr_acc  = ~CS_N & ~IOREQ & ~W;
    assign wr_edge = wr_acc & ~wr_acc_q;
    assign stat_wr = wr_edge & ADDR0;
    assign flush   = wr_edge & ~ADDR0 & DATA_IN[0];
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign nempty  = (count_q != '0);
    assign pop_req = rd_acc_q & ~rd_acc & ~addr0_q & nempty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        ovf_set  = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_push = push_req & (~full | pop_req);
            ovf_set = push_req & full & ~pop_req;
            if (do_push) begin
                mem_d[wr_ptr_q] = shift_q;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_req)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(pop_req);
        end
        // A new error in the same cycle as its W1C clear wins
        ferr_d   = (ferr_q & ~(stat_wr & DATA_IN[4])) | ferr_set;
        perr_d   = (perr_q & ~(stat_wr & DATA_IN[3])) | perr_set;
        ovf_d    = (ovf_q  & ~(stat_wr & DATA_IN[2])) | ovf_set;
        ie_d     = stat_wr ? DATA_IN[7] : ie_q;
        rd_acc_d = rd_acc;
        wr_acc_d = wr_acc;
        addr0_d  = rd_acc ? ADDR0 : addr0_q;
        int_n_d  = ~(ie_q & (nempty | ovf_q | perr_q | ferr_q));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            kb_clk_s1_q  <= 1'b1;
            kb_clk_s2_q  <= 1'b1;
            kb_data_s1_q <= 1'b1;
            kb_data_s2_q <= 1'b1;
            sample_cnt_q <= '0;
            timeout_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            mem_q        <= '{default: 8'h00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            ovf_q        <= 1'b0;
            ie_q         <= 1'b0;
            int_n_q      <= 1'b1;
            rd_acc_q     <= 1'b0;
            wr_acc_q     <= 1'b0;
            addr0_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kb_clk_s1_q  <= kb_clk_s1_d;
            kb_clk_s2_q  <= kb_clk_s2_d;
            kb_data_s1_q <= kb_data_s1_d;
            kb_data_s2_q <= kb_data_s2_d;
            sample_cnt_q <= sample_cnt_d;
            timeout_q    <= timeout_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            ovf_q        <= ovf_d;
            ie_q         <= ie_d;
            int_n_q      <= int_n_d;
            rd_acc_q     <= rd_acc_d;
            wr_acc_q     <= wr_acc_d;
            addr0_q      <= addr0_d;
        end
    end

    assign status   = {ie_q, 2'b00, ferr_q, perr_q, ovf_q, full, nempty};
    assign head     = nempty ? mem_q[rd_ptr_q] : 8'h00;
    assign DATA_OE  = rd_acc & ~RST;
    assign DATA_OUT = DATA_OE ? (ADDR0 ? status : head) : 8'h00;
    assign INT_N    = int_n_q;

endmodule

`default_nettype wire

// File: doc/ps2_kbd_controller.md
Name: ps2_kbd_controller

Overview:
- CPU-facing PS/2 keyboard receiver for the Flounder Z180 glue CPLD.
- Occupies the CPLD I/O select at 0x4000.
- Deglitches KB_CLK/KB_DATA, deserialises 11-bit PS/2 frames and checks start, parity and stop bits.
- Buffers scan codes in a FIFO and exposes DATA/STATUS registers plus a maskable interrupt to the Z180.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of two, ≥2
SAMPLE_DELAY, 8, CLK cycles KB_CLK must stay low before KB_DATA is sampled
TIMEOUT_CYCLES, 36864, idle CLK cycles mid-frame before abort (~2 ms at 18.432 MHz)

Ports:
CLK  input  1  system clock; all state on rising edge
RST  input  1  asynchronous reset, active-high
CS_N  input  1  CPLD I/O select, active-low, decoded externally
IOREQ  input  1  Z180 /IORQ, active-low
R  input  1  Z180 /RD, active-low
W  input  1  Z180 /WR, active-low
ADDR0  input  1  register select: 0=DATA, 1=STATUS
DATA_IN  input  8  CPU write data
DATA_OUT  output  8  CPU read data
DATA_OE  output  1  high while a read access is active; drives the bus tristate
KB_CLK  input  1  PS/2 clock, asynchronous
KB_DATA  input  1  PS/2 data, asynchronous
INT_N  output  1  interrupt request, active-low, registered

Behaviour:
- Reset values: DATA_OUT=0x00, DATA_OE=0, INT_N=1, FIFO empty, all flags 0, IE=0, receiver IDLE.
- Synchroniser:
  - Two-flop sync on KB_CLK and KB_DATA.
  - Sample counter increments while synced clock is low and clears when high.
  - When the counter equals SAMPLE_DELAY, one bit is taken; at most one bit per low period.
- Receiver FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE: sampled bit 0 goes to DATA; sampled bit 1 is ignored (glitch), stay IDLE.
  - PARITY: parity bit is stored; odd parity over the 8 data bits plus the parity bit is required.
  - STOP, stop bit=1 and parity OK: push byte.
  - STOP, stop bit=0: FERR=1, byte discarded.
  - STOP, parity wrong (stop bit=1): PERR=1, byte discarded.
  - Timeout counter runs in any non-IDLE state and clears on every sample. On reaching TIMEOUT_CYCLES: FERR=1, return to IDLE, partial byte discarded.
- Bus access:
  - Read access = ~CS_N & ~IOREQ & ~R; write access = ~CS_N & ~IOREQ & ~W.
  - DATA_OE follows the read access combinationally.
- DATA_OUT:
  - ADDR0=0: FIFO head, or 0x00 if empty.
  - ADDR0=1: STATUS = {IE, 2'b0, FERR, PERR, OVF, FULL, NEMPTY}, bit7..bit0.
- Pop:
  - ADDR0 is registered during the read access.
  - One pop occurs on the first CLK after the access deasserts, if the registered ADDR0=0 and the FIFO is not empty.
  - A multi-cycle read pops exactly once.
- Writes take effect on the first CLK edge of the write access only (edge-detected).
  - STATUS write: IE=DATA_IN[7]; DATA_IN[4:2] bits set to 1 clear FERR/PERR/OVF (W1C).
  - DATA write with DATA_IN[0]=1: flush FIFO.
- Push to a full FIFO: byte dropped, OVF=1.
  - Same-cycle pop and push when full: both performed, no OVF.
- Same-cycle flush and push: flush wins, FIFO empty, no OVF.
- Same-cycle W1C clear and new error: the flag ends set.
- Count arithmetic:
  - Pointers are log2(FIFO_DEPTH) bits, wrapping modulo depth.
  - Count is log2(FIFO_DEPTH)+1 bits, saturating at 0 and FIFO_DEPTH.
- INT_N = ~(IE & (NEMPTY | OVF | PERR | FERR)), registered, one CLK latency.
- RST asserted mid-frame or mid-access: immediate return to reset values; no pop or push is committed.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → STATUS=0x01, DATA read → 0x1C, then STATUS=0x00.
- IE=1 (write STATUS 0x80), send 0xF0 → INT_N low 1 CLK after push; after DATA read pop → INT_N high.
- Send 9 valid bytes 0x01..0x09 with no reads → STATUS=0x07 (FULL, OVF, NEMPTY); reads return 0x01..0x08, then 0x00; write STATUS 0x04 → OVF clears.
- Frame 0x1C with parity 1 → PERR=1, FIFO empty; frame with stop 0 → FERR=1, FIFO empty.
- Stop KB_CLK after 4 data bits → after TIMEOUT_CYCLES FERR=1, FSM IDLE; next valid frame 0x5A received intact.
- 1-CLK KB_CLK low glitch (< SAMPLE_DELAY) → no bit sampled; 5-cycle DATA read access → exactly one pop; RST pulse mid-frame → all outputs at reset values.
